// File: rtl/abs24_if.sv
// Operand/result bundle for abs24: the two 24-bit operands and the 48-bit running sum.
// The master drives the operands; the slave (abs24) drives the sum.
interface abs24_if;
    logic [23:0] AIN;
    logic [23:0] BIN;
    logic [47:0] ABS_SUM_OUT;

    modport master (output AIN, output BIN, input ABS_SUM_OUT);
    modport slave  (input AIN, input BIN, output ABS_SUM_OUT);
endinterface

// File: rtl/abs24.sv
// abs24: 3-stage pipeline accumulating |A-B| into a 48-bit wrapping sum.
// Define ABS24_SIGNED_EN to treat AIN/BIN as two's-complement; unsigned otherwise.
module abs24 (
    input  logic   CLK,
    input  logic   RST,
    abs24_if.slave io
);
    logic [23:0] a1_q, a1_d;
    logic [23:0] b1_q, b1_d;
    logic [23:0] mag_q, mag_d;
    logic [47:0] acc_q, acc_d;
    logic [24:0] diff;

    always_comb begin
        a1_d = io.AIN;
        b1_d = io.BIN;
`ifdef ABS24_SIGNED_EN
        diff = {a1_q[23], a1_q} - {b1_q[23], b1_q};
`else
        diff = {1'b0, a1_q} - {1'b0, b1_q};
`endif
        // The largest magnitude either way is 2^24-1, so negating into 24 bits is exact.
        mag_d = diff[24] ? 24'(-diff) : diff[23:0];
        acc_d = acc_q + {24'd0, mag_q};
    end

    // NOTE: non-blocking assignments let every stage sample the previous stage's
    // old value on the same edge; blocking here would collapse the pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a1_q  <= '0;
            b1_q  <= '0;
            mag_q <= '0;
            acc_q <= '0;
        end else begin
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            mag_q <= mag_d;
            acc_q <= acc_d;
        end
    end

    assign io.ABS_SUM_OUT = acc_q;
endmodule

// File: tb/tb_abs24.sv
// Directed bench for abs24: per-cycle vector table plus hand-written reset and
// boundary sequences; expectations are hand-computed for either build.
module tb_abs24;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    abs24_if bus ();

    abs24 dut (
        .CLK(clk),
        .RST(rst),
        .io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] exp_sum;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%012h expected 0x%012h", name, act, exp_v);
        end
    endtask

    // Apply inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic r, input logic [23:0] a, input logic [23:0] b);
        rst     = r;
        bus.AIN = a;
        bus.BIN = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic r, input logic [23:0] a,
                       input logic [23:0] b, input logic [47:0] e);
        vec_t v;
        v.name = name; v.rst = r; v.a = a; v.b = b; v.exp_sum = e;
        vecs.push_back(v);
    endtask

    logic [47:0] exp_sum;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.AIN      = 'x;
        bus.BIN      = 'x;

        // Reset with unknown operands, then the 3/5, 2020/2000, 10/14, 1115/1111 runs.
        add("rst0", 1'b1, 'x, 'x, 48'd0);
        add("rst1", 1'b1, 'x, 'x, 48'd0);
        add("d2_0", 1'b0, 24'd3, 24'd5, 48'd0);
        add("d2_1", 1'b0, 24'd3, 24'd5, 48'd0);
        add("d2_2", 1'b0, 24'd3, 24'd5, 48'd2);
        add("d2_3", 1'b0, 24'd3, 24'd5, 48'd4);
        add("d2_4", 1'b0, 24'd3, 24'd5, 48'd6);
        add("d2_5", 1'b0, 24'd3, 24'd5, 48'd8);
        add("d20_0", 1'b0, 24'd2020, 24'd2000, 48'd10);
        add("d20_1", 1'b0, 24'd2020, 24'd2000, 48'd12);
        add("d20_2", 1'b0, 24'd2020, 24'd2000, 48'd32);
        add("d20_3", 1'b0, 24'd2020, 24'd2000, 48'd52);
        add("d20_4", 1'b0, 24'd2020, 24'd2000, 48'd72);
        add("d20_5", 1'b0, 24'd2020, 24'd2000, 48'd92);
        add("d4n_0", 1'b0, 24'd10, 24'd14, 48'd112);
        add("d4n_1", 1'b0, 24'd10, 24'd14, 48'd132);
        add("d4n_2", 1'b0, 24'd10, 24'd14, 48'd136);
        add("d4n_3", 1'b0, 24'd10, 24'd14, 48'd140);
        add("d4n_4", 1'b0, 24'd10, 24'd14, 48'd144);
        add("d4n_5", 1'b0, 24'd10, 24'd14, 48'd148);
        add("d4p_0", 1'b0, 24'd1115, 24'd1111, 48'd152);
        add("d4p_1", 1'b0, 24'd1115, 24'd1111, 48'd156);
        add("d4p_2", 1'b0, 24'd1115, 24'd1111, 48'd160);
        add("d4p_3", 1'b0, 24'd1115, 24'd1111, 48'd164);
        add("d4p_4", 1'b0, 24'd1115, 24'd1111, 48'd168);
        add("d4p_5", 1'b0, 24'd1115, 24'd1111, 48'd172);
        add("drain0", 1'b0, 24'd0, 24'd0, 48'd176);
        add("drain1", 1'b0, 24'd0, 24'd0, 48'd180);
        add("drain2", 1'b0, 24'd0, 24'd0, 48'd180);
        for (int i = 0; i < 10; i++)
            add($sformatf("eq_%0d", i), 1'b0, 24'hABCDEF, 24'hABCDEF, 48'd180);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b);
            check(vecs[i].name, bus.ABS_SUM_OUT, vecs[i].exp_sum);
        end

        // Extreme operands straight out of reset: 0xFFFFFF vs 1 for a single cycle.
        step(1'b1, 24'h123456, 24'h654321);
        check("ext_rst", bus.ABS_SUM_OUT, 48'd0);
        step(1'b0, 24'hFFFFFF, 24'h000001);
        check("ext_k", bus.ABS_SUM_OUT, 48'd0);
        step(1'b0, 24'h000055, 24'h000055);
        check("ext_k1", bus.ABS_SUM_OUT, 48'd0);
`ifdef ABS24_SIGNED_EN
        exp_sum = 48'h000002;
`else
        exp_sum = 48'hFFFFFE;
`endif
        step(1'b0, 24'h000055, 24'h000055);
        check("ext_k2", bus.ABS_SUM_OUT, exp_sum);
        step(1'b0, 24'h000055, 24'h000055);
        check("ext_hold", bus.ABS_SUM_OUT, exp_sum);

        // Most-negative minus most-positive: 0xFFFFFF signed, 1 unsigned.
        step(1'b0, 24'h800000, 24'h7FFFFF);
        check("minmax_k", bus.ABS_SUM_OUT, exp_sum);
        step(1'b0, 24'h000000, 24'h000000);
        check("minmax_k1", bus.ABS_SUM_OUT, exp_sum);
`ifdef ABS24_SIGNED_EN
        exp_sum = exp_sum + 48'hFFFFFF;
`else
        exp_sum = exp_sum + 48'h000001;
`endif
        step(1'b0, 24'h000000, 24'h000000);
        check("minmax_k2", bus.ABS_SUM_OUT, exp_sum);

        // B > A at the range limits: 0 - 0xFFFFFF.
        step(1'b0, 24'h000000, 24'hFFFFFF);
        step(1'b0, 24'h000000, 24'h000000);
`ifdef ABS24_SIGNED_EN
        exp_sum = exp_sum + 48'h000001;
`else
        exp_sum = exp_sum + 48'hFFFFFF;
`endif
        step(1'b0, 24'h000000, 24'h000000);
        check("bgta_k2", bus.ABS_SUM_OUT, exp_sum);

        // Mid-stream reset with A=7, B=0 held throughout.
        for (int i = 0; i < 4; i++) step(1'b0, 24'd7, 24'd0);
        check("pre_rst", bus.ABS_SUM_OUT, exp_sum + 48'd14);
        step(1'b1, 24'd7, 24'd0);
        check("mid_rst", bus.ABS_SUM_OUT, 48'd0);
        step(1'b0, 24'd7, 24'd0);
        check("flush1", bus.ABS_SUM_OUT, 48'd0);
        step(1'b0, 24'd7, 24'd0);
        check("flush2", bus.ABS_SUM_OUT, 48'd0);
        step(1'b0, 24'd7, 24'd0);
        check("resume1", bus.ABS_SUM_OUT, 48'd7);
        step(1'b0, 24'd7, 24'd0);
        check("resume2", bus.ABS_SUM_OUT, 48'd14);
        step(1'b0, 24'd7, 24'd0);
        check("resume3", bus.ABS_SUM_OUT, 48'd21);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/abs24.md
ABS24 -- requirements
Module: abs24

Interface
REQ-001 Parameters: none; data width 24 bits and accumulator width 48 bits are fixed.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 AIN  input  24  operand A, sampled every cycle.
REQ-005 BIN  input  24  operand B, sampled every cycle.
REQ-006 ABS_SUM_OUT  output  48  running sum of |A-B|, driven directly from a register.

Function
REQ-007 The block SHALL implement a 3-stage pipeline with no handshake; a new sample is accepted every cycle.
REQ-008 Stage 1 SHALL register AIN and BIN on every clock edge.
REQ-009 Stage 2 SHALL compute D = A1 - B1 in 25 bits: zero-extended when unsigned, sign-extended when signed (REQ-017).
REQ-010 Stage 2 SHALL register |D| as a 24-bit unsigned magnitude; A1 = B1 gives 0.
REQ-011 Stage 3 SHALL add the zero-extended magnitude to a 48-bit accumulator every cycle; ABS_SUM_OUT is the accumulator.
REQ-012 Latency: the sample present at edge k SHALL first be included in ABS_SUM_OUT after edge k+2.
REQ-013 Accumulator overflow SHALL wrap modulo 2^48, with no flag and no saturation.
REQ-014 Unknown inputs sampled during reset SHALL NOT affect any state.

Reset
REQ-015 While RST=1 at a rising edge, the stage-1 registers, stage-2 register and accumulator SHALL all load 0; ABS_SUM_OUT reads 0 from the following edge.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight samples. After RST falls, the first sample registered at edge k SHALL appear after edge k+2. Each stage's reset-zero contributes +0.

Configuration
REQ-017 Macro ABS24_SIGNED_EN:
- Defined: AIN and BIN are 24-bit two's-complement signed values.
- Undefined (default): AIN and BIN are unsigned.
- In both modes the magnitude fits in 24 bits.

Verification
REQ-018 Reset held 2 cycles, then A=3, B=5 for 6 cycles -> ABS_SUM_OUT = 0 until 2 edges after the first sample edge, then increments by 2 per cycle, reaching 12.
REQ-019 From 12: A=2020, B=2000 for 6 cycles, then A=10, B=14 for 6 cycles, then A=1115, B=1111 for 6 cycles -> +20, then +4, then +4 per cycle; final value 12+120+24+24 = 180, each step delayed by 2 cycles.
REQ-020 A=B=0xABCDEF for 10 cycles -> ABS_SUM_OUT constant once the pipeline drains.
REQ-021 A=0xFFFFFF, B=0x000001 for 1 cycle from reset, then A=B -> unsigned build: 0xFFFFFE; ABS24_SIGNED_EN build: 0x000002.
REQ-022 Signed build: A=0x800000, B=0x7FFFFF for 1 cycle -> sum increases by 0xFFFFFF.
REQ-023 RST asserted for 1 cycle mid-stream, with A=7, B=0 continuous -> ABS_SUM_OUT = 0 after the reset edge. The sum then stays 0 for two more edges (flushed pipeline zeros), then increments by 7 per cycle.
